// File: rtl/inv_mix_columns_seq.sv
// ----------------------------------------------------------------------------
// inv_mix_columns_seq
//
// Sequential InvMixColumns stage of the AES-128 decryption datapath. A
// 128-bit state is taken over a valid/ready handshake, transformed in place
// COLS_PER_CYCLE columns per clock, and presented over a second valid/ready
// handshake. A per-transaction bypass flag passes the state through unchanged
// (final decryption round) with the same latency as a normal transaction.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input state valid
//   in_ready   stage can accept a state this cycle
//   in_state   input state, column-major; byte k at [127-8k -: 8]
//   in_bypass  sampled with in_state; 1 = pass through unchanged
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_state  result state (the work register)
//
// Parameters:
//   COLS_PER_CYCLE  columns processed per clock: 1, 2 or 4
// ----------------------------------------------------------------------------
module inv_mix_columns_seq #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Step of 4 truncates to 0: with four columns per cycle the counter never moves.
    localparam logic [1:0] CntStep = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LastCnt = 2'(4 - COLS_PER_CYCLE);

    // ------------------------------------------------------------------------
    // GF(2^8) constant multipliers, reduction polynomial x^8+x^4+x^3+x+1
    // ------------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul_09(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] mul_0b(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] mul_0d(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] mul_0e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // One column; row 0 sits in the most significant byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] s0, s1, s2, s3;
        logic [7:0] r0, r1, r2, r3;
        s0 = col[31:24];
        s1 = col[23:16];
        s2 = col[15:8];
        s3 = col[7:0];
        r0 = mul_0e(s0) ^ mul_0b(s1) ^ mul_0d(s2) ^ mul_09(s3);
        r1 = mul_09(s0) ^ mul_0e(s1) ^ mul_0b(s2) ^ mul_0d(s3);
        r2 = mul_0d(s0) ^ mul_09(s1) ^ mul_0e(s2) ^ mul_0b(s3);
        r3 = mul_0b(s0) ^ mul_0d(s1) ^ mul_09(s2) ^ mul_0e(s3);
        return {r0, r1, r2, r3};
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]   state_q, state_d;
    logic [127:0] work_q, work_d;
    logic         bypass_q, bypass_d;
    logic [1:0]   cnt_q, cnt_d;

    // ------------------------------------------------------------------------
    // Column datapath: COLS_PER_CYCLE column lanes starting at cnt_q
    // ------------------------------------------------------------------------
    logic [31:0] col_q [4];
    logic [1:0]  grp_idx [COLS_PER_CYCLE];
    logic [31:0] grp_new [COLS_PER_CYCLE];
    logic [127:0] busy_work;

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign col_q[c] = work_q[127-32*c -: 32];
    end

    for (genvar g = 0; g < int'(COLS_PER_CYCLE); g++) begin : g_lane
        assign grp_idx[g] = cnt_q + 2'(g);
        assign grp_new[g] = bypass_q ? col_q[grp_idx[g]] : inv_mix_col(col_q[grp_idx[g]]);
    end

    always_comb begin
        busy_work = work_q;
        for (int c = 0; c < 4; c++) begin
            for (int g = 0; g < int'(COLS_PER_CYCLE); g++) begin
                if (grp_idx[g] == 2'(c)) begin
                    busy_work[127-32*c -: 32] = grp_new[g];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------------
    always_comb begin
        logic load;
        load      = 1'b0;
        state_d   = state_q;
        work_d    = work_q;
        bypass_d  = bypass_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                load     = in_valid;
            end
            StBusy: begin
                work_d = busy_work;
                cnt_d  = cnt_q + CntStep;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                // Consuming the result frees the work register in the same cycle,
                // so a waiting input can be taken back-to-back.
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load) begin
            work_d   = in_state;
            bypass_d = in_bypass;
            cnt_d    = 2'd0;
            state_d  = StBusy;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            work_q   <= '0;
            bypass_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            bypass_q <= bypass_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_state = work_q;

endmodule
